// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared keccak word width and arbiter types
package keccak_pkg;
  localparam int w = 64;
  localparam int OUT_CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {IDLE, ABSORB, SQUEEZE, RELEASE} arb_state_t;
endpackage

// File: rtl/keccak_arbiter_rr_pick.sv
// rtl/keccak_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [IDX_W-1:0] j;

  // Scan from ptr upward with wrap; the first set bit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      j = IDX_W'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/keccak_arbiter.sv
// rtl/keccak_arbiter.sv - round-robin sharing of one keccak core among requesters
module keccak_arbiter
  import keccak_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int OUT_CNT_W = OUT_CNT_W_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                in_valid_i,
  input  logic [N_REQ-1:0][w-1:0]         in_data_i,
  input  logic [N_REQ-1:0]                in_last_i,
  input  logic [N_REQ-1:0][OUT_CNT_W-1:0] out_words_i,
  output logic [N_REQ-1:0]                in_ready_o,
  output logic [N_REQ-1:0]                out_valid_o,
  output logic [w-1:0]                    out_data_o,
  input  logic [N_REQ-1:0]                out_ready_i,
  output logic                            core_valid_o,
  output logic [w-1:0]                    core_data_o,
  input  logic                            core_ready_i,
  input  logic                            core_valid_i,
  input  logic [w-1:0]                    core_data_i,
  output logic                            core_ready_o,
  output logic [N_REQ-1:0]                grant_o,
  output logic                            busy_o
);
  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t           state, state_next;
  logic [N_REQ-1:0]     grant;
  logic [IDX_W-1:0]     gidx;
  logic [IDX_W-1:0]     ptr;
  logic [OUT_CNT_W-1:0] cnt;

  logic [N_REQ-1:0]     pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 absorb_xfer;
  logic                 squeeze_xfer;

  rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req (in_valid_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign absorb_xfer  = (state == ABSORB)  && in_valid_i[gidx] && core_ready_i;
  assign squeeze_xfer = (state == SQUEEZE) && core_valid_i && out_ready_i[gidx];
  assign grant_o      = grant;
  assign busy_o       = (state != IDLE);

  always_comb begin
    state_next   = state;
    in_ready_o   = '0;
    out_valid_o  = '0;
    out_data_o   = '0;
    core_valid_o = 1'b0;
    core_data_o  = '0;
    core_ready_o = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) state_next = ABSORB;
      end
      ABSORB: begin
        core_valid_o     = in_valid_i[gidx];
        core_data_o      = in_data_i[gidx];
        in_ready_o[gidx] = core_ready_i;
        if (absorb_xfer && in_last_i[gidx]) state_next = SQUEEZE;
      end
      SQUEEZE: begin
        out_valid_o[gidx] = core_valid_i;
        out_data_o        = core_data_i;
        core_ready_o      = out_ready_i[gidx];
        if (squeeze_xfer && cnt == OUT_CNT_W'(1)) state_next = RELEASE;
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick_gnt;
            gidx  <= pick_idx;
            // A zero word count still squeezes one word so the packet terminates.
            cnt   <= (out_words_i[pick_idx] == '0) ? OUT_CNT_W'(1) : out_words_i[pick_idx];
          end
        end
        SQUEEZE: begin
          if (squeeze_xfer) cnt <= cnt - OUT_CNT_W'(1);
        end
        RELEASE: begin
          grant <= '0;
          ptr   <= (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_keccak_arbiter.sv
// tb/tb_keccak_arbiter.sv - directed self-checking bench for keccak_arbiter
module tb_keccak_arbiter;
  import keccak_pkg::*;

  localparam int N  = 4;
  localparam int CW = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           in_valid_i;
  logic [N-1:0][w-1:0]    in_data_i;
  logic [N-1:0]           in_last_i;
  logic [N-1:0][CW-1:0]   out_words_i;
  logic [N-1:0]           in_ready_o;
  logic [N-1:0]           out_valid_o;
  logic [w-1:0]           out_data_o;
  logic [N-1:0]           out_ready_i;
  logic                   core_valid_o;
  logic [w-1:0]           core_data_o;
  logic                   core_ready_i;
  logic                   core_valid_i;
  logic [w-1:0]           core_data_i;
  logic                   core_ready_o;
  logic [N-1:0]           grant_o;
  logic                   busy_o;

  keccak_arbiter #(.N_REQ(N), .OUT_CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_last_i    (in_last_i),
    .out_words_i  (out_words_i),
    .in_ready_o   (in_ready_o),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_ready_i  (out_ready_i),
    .core_valid_o (core_valid_o),
    .core_data_o  (core_data_o),
    .core_ready_i (core_ready_i),
    .core_valid_i (core_valid_i),
    .core_data_i  (core_data_i),
    .core_ready_o (core_ready_o),
    .grant_o      (grant_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [63:0]  txq[N][$];
  logic [63:0]  core_log[$];
  logic [63:0]  out_log0[$];
  logic [N-1:0] grant_seq[$];
  logic [N-1:0] prev_grant;
  int           out_beats[N];
  int           stray, ir_low, ocr_low, cdata_n;
  logic         cready, cvalid;
  logic [N-1:0] orr;
  logic [63:0]  t1_words[18];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (txq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle: drive from the requester/core models, observe mid-cycle, advance.
  task automatic step();
    for (int i = 0; i < N; i++) begin
      in_valid_i[i] = (txq[i].size() > 0);
      in_data_i[i]  = (txq[i].size() > 0) ? txq[i][0] : 64'h0;
      in_last_i[i]  = (txq[i].size() == 1);
    end
    out_ready_i  = orr;
    core_ready_i = cready;
    core_valid_i = cvalid;
    core_data_i  = 64'hC0DE_0000_0000_0000 + 64'(cdata_n);
    #1;
    if (core_valid_o && core_ready_i) core_log.push_back(core_data_o);
    if (core_ready_o && core_valid_i) cdata_n++;
    if (grant_o != '0 && prev_grant == '0) grant_seq.push_back(grant_o);
    prev_grant = grant_o;
    for (int i = 0; i < N; i++) begin
      if (out_valid_o[i] && out_ready_i[i]) begin
        out_beats[i]++;
        if (i == 0) out_log0.push_back(out_data_o);
      end
      if (!grant_o[i] && (in_ready_o[i] || out_valid_o[i])) stray++;
      if (grant_o[i] && in_valid_i[i] && !in_ready_o[i]) ir_low++;
      if (grant_o[i] && out_valid_o[i] && !core_ready_o) ocr_low++;
      if (in_valid_i[i] && in_ready_o[i]) void'(txq[i].pop_front());
    end
    @(negedge clk);
  endtask

  task automatic load(input int i, input int n, input logic [63:0] base, input int ow);
    for (int k = 0; k < n; k++) txq[i].push_back(base + 64'(k));
    out_words_i[i] = CW'(ow);
  endtask

  task automatic run_until_idle(input int budget);
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while ((busy_o || pending()) && c < budget);
    check("idle_timeout", 64'(c >= budget), 64'd0);
  endtask

  task automatic clear_stats();
    core_log.delete();
    out_log0.delete();
    grant_seq.delete();
    for (int i = 0; i < N; i++) out_beats[i] = 0;
    stray = 0; ir_low = 0; ocr_low = 0; cdata_n = 0;
  endtask

  initial begin
    int c;
    rst = 1'b0;
    cready = 1'b1; cvalid = 1'b1; orr = '1; prev_grant = '0;
    clear_stats();
    in_valid_i = '1; in_data_i = '0; in_last_i = '0; out_words_i = '0;
    out_ready_i = '1; core_ready_i = 1'b1; core_valid_i = 1'b1; core_data_i = 64'h1234;
    t1_words[0] = 64'h8000010000000020;
    t1_words[1] = 64'h0615502300000000;
    for (int k = 2; k < 18; k++) t1_words[k] = 64'h0;

    // Reset state with every input asserted
    #12;
    check("rst_grant", 64'(grant_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd0);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_core_valid", 64'(core_valid_o), 64'd0);
    check("rst_core_ready", 64'(core_ready_o), 64'd0);
    check("rst_out_data", out_data_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("idle_busy", 64'(busy_o), 64'd0);

    // Requesters 0 and 2 together, pointer 0
    clear_stats();
    load(0, 2, 64'h100, 1);
    load(2, 2, 64'h200, 1);
    run_until_idle(200);
    check("rr_a_len", 64'(grant_seq.size()), 64'd2);
    check("rr_a_0", 64'(grant_seq[0]), 64'b0001);
    check("rr_a_1", 64'(grant_seq[1]), 64'b0100);

    // Requesters 0,1,2 together, pointer 3 wraps to 0
    clear_stats();
    load(0, 1, 64'h110, 1);
    load(1, 1, 64'h120, 1);
    load(2, 1, 64'h130, 1);
    run_until_idle(200);
    check("rr_b_len", 64'(grant_seq.size()), 64'd3);
    check("rr_b_0", 64'(grant_seq[0]), 64'b0001);
    check("rr_b_1", 64'(grant_seq[1]), 64'b0010);
    check("rr_b_2", 64'(grant_seq[2]), 64'b0100);

    // Single requester, 18-word packet, 4 output words
    clear_stats();
    for (int k = 0; k < 18; k++) txq[0].push_back(t1_words[k]);
    out_words_i[0] = CW'(4);
    step();
    check("t1_grant", 64'(grant_o), 64'b0001);
    check("t1_no_word_at_grant", 64'(core_log.size()), 64'd0);
    step();
    check("t1_first_word", 64'(core_log.size()), 64'd1);
    c = 0;
    while (out_beats[0] < 4 && c < 100) begin
      step();
      c++;
    end
    check("t1_beats_timeout", 64'(c >= 100), 64'd0);
    check("t1_release_busy", 64'(busy_o), 64'd1);
    check("t1_release_grant", 64'(grant_o), 64'b0001);
    check("t1_release_out_valid", 64'(out_valid_o), 64'd0);
    check("t1_release_core_ready", 64'(core_ready_o), 64'd0);
    step();
    check("t1_idle_busy", 64'(busy_o), 64'd0);
    check("t1_idle_grant", 64'(grant_o), 64'd0);
    check("t1_out_beats", 64'(out_beats[0]), 64'd4);
    check("t1_core_words", 64'(core_log.size()), 64'd18);
    for (int k = 0; k < 18; k++) check($sformatf("t1_word%0d", k), core_log[k], t1_words[k]);
    check("t1_out_data0", out_log0[0], 64'hC0DE_0000_0000_0000);
    check("t1_out_data3", out_log0[3], 64'hC0DE_0000_0000_0003);

    // Back-pressure on requester 1 while requester 3 waits with out_words=0
    clear_stats();
    load(1, 6, 64'h1000, 8);
    load(3, 2, 64'h3000, 0);
    step(); step(); step();
    cready = 1'b0;
    repeat (3) step();
    cready = 1'b1;
    c = 0;
    while (out_beats[1] < 2 && c < 100) begin
      step();
      c++;
    end
    check("bp_beats_timeout", 64'(c >= 100), 64'd0);
    orr[1] = 1'b0;
    repeat (5) step();
    orr[1] = 1'b1;
    run_until_idle(300);
    check("bp_in_ready_low", 64'(ir_low), 64'd3);
    check("bp_core_ready_low", 64'(ocr_low), 64'd5);
    check("bp_stray", 64'(stray), 64'd0);
    check("bp_out_beats1", 64'(out_beats[1]), 64'd8);
    check("zero_words_beats3", 64'(out_beats[3]), 64'd1);
    check("bp_core_words", 64'(core_log.size()), 64'd8);
    for (int k = 0; k < 6; k++) check($sformatf("bp_word%0d", k), core_log[k], 64'h1000 + 64'(k));
    check("bp_word_req3", core_log[6], 64'h3000);

    // Leave the pointer at 1, then reset mid-SQUEEZE of requester 2
    load(0, 1, 64'h4000, 1);
    run_until_idle(100);
    clear_stats();
    load(2, 3, 64'h5000, 5);
    c = 0;
    while (out_beats[2] < 2 && c < 100) begin
      step();
      c++;
    end
    check("rst_beats_timeout", 64'(c >= 100), 64'd0);
    #3;
    rst = 1'b0;
    #1;
    check("arst_grant", 64'(grant_o), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_out_valid", 64'(out_valid_o), 64'd0);
    check("arst_core_ready", 64'(core_ready_o), 64'd0);
    check("arst_core_valid", 64'(core_valid_o), 64'd0);
    check("arst_out_data", out_data_o, 64'd0);
    for (int i = 0; i < N; i++) txq[i].delete();
    prev_grant = '0;
    @(negedge clk);
    rst = 1'b1;
    clear_stats();
    load(0, 1, 64'h6000, 1);
    load(1, 1, 64'h7000, 1);
    run_until_idle(200);
    check("post_rst_first", 64'(grant_seq[0]), 64'b0001);
    check("post_rst_second", 64'(grant_seq[1]), 64'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule

// File: doc/keccak_arbiter.md
Name: keccak_arbiter

Overview:
- Shares one keccak core among N_REQ requesters, one packet at a time (header word + message words, then squeezed output words).
- Sits between the requester streams and the core's valid_i/ready_i/data_in and valid_o/ready_o/data_out ports.
- Grants are round-robin and held for the whole packet.
- Routes core output only to the granted requester until the requested number of output words has been delivered.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- OUT_CNT_W, 16, width of the per-packet output word count.
- w, from keccak_pkg (64), data word width; not overridable here.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- in_valid_i  in  N_REQ  requester i has an input word; in IDLE this is the request
- in_data_i  in  N_REQ x w  requester input words
- in_last_i  in  N_REQ  marks the final input word of the packet
- out_words_i  in  N_REQ x OUT_CNT_W  output words expected; sampled at grant
- in_ready_o  out  N_REQ  input accepted from requester i
- out_valid_o  out  N_REQ  output word valid for requester i
- out_data_o  out  w  output word, broadcast to all requesters
- out_ready_i  in  N_REQ  requester i accepts the output word
- core_valid_o  out  1  to core valid_i
- core_data_o  out  w  to core data_in
- core_ready_i  in  1  from core ready_o
- core_valid_i  in  1  from core valid_o
- core_data_i  in  w  from core data_out
- core_ready_o  out  1  to core ready_i
- grant_o  out  N_REQ  one-hot current owner; 0 when idle
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, grant_o=0, priority pointer=0, output counter=0.
  - All *_valid_o, in_ready_o and core_ready_o are 0; busy_o=0.
  - Reset mid-packet aborts immediately; the core is reset by its own reset.
- States IDLE -> ABSORB -> SQUEEZE -> RELEASE -> IDLE.
- IDLE:
  - Requests are the bits of in_valid_i.
  - Pick the first set bit scanning from the pointer upward, wrapping.
  - On the next edge: register the one-hot grant; latch out_words_i[g] into the counter (0 is treated as 1); go to ABSORB.
  - No data moves in IDLE: in_ready_o=0, core_valid_o=0.
- ABSORB:
  - Combinational pass-through: core_valid_o=in_valid_i[g], core_data_o=in_data_i[g], in_ready_o[g]=core_ready_i. Other in_ready_o bits stay 0.
  - A word transfers when in_valid_i[g] & core_ready_i.
  - Transfer with in_last_i[g]=1 -> SQUEEZE.
  - A deasserted in_valid_i[g] simply stalls; the grant is never revoked.
- SQUEEZE:
  - out_valid_o[g]=core_valid_i, out_data_o=core_data_i, core_ready_o=out_ready_i[g]. core_valid_o=0.
  - Each transfer (core_valid_i & out_ready_i[g]) decrements the counter.
  - Transfer at counter==1 -> RELEASE.
- RELEASE (1 cycle):
  - All handshakes deasserted.
  - pointer = (g+1) mod N_REQ; grant cleared; -> IDLE.
- Outside SQUEEZE: core_ready_o=0 and out_valid_o=0, so core output is back-pressured, never dropped.
- out_data_o: equals core_data_i in SQUEEZE; 0 otherwise.
- Fairness: an asserted request waits at most N_REQ-1 packets.
- Latency:
  - First input word reaches the core 2 cycles after in_valid_i rises in IDLE (grant edge, then ABSORB pass-through).
  - No added latency in ABSORB/SQUEEZE.
  - Minimum per-packet overhead is 2 cycles (IDLE + RELEASE).
- Simultaneous events: a new in_valid_i arriving in RELEASE is evaluated in the following IDLE with the updated pointer.

Decomposition:
- keccak_pkg gains:
  - typedef enum arb_state_t {IDLE, ABSORB, SQUEEZE, RELEASE}
  - localparam OUT_CNT_W_DEFAULT = 16
  - w is reused from the package.
- Sub-module rr_pick: combinational round-robin picker (req vector, pointer) -> one-hot grant + index. Unit-tested separately.

Test Plan:
- Single requester 0, out_words=4, words 64'h8000010000000020, 64'h0615502300000000, then 16 x 0 (last on 18th) -> all 18 on core_data_o in order; exactly 4 out_valid_o[0] beats; 1 RELEASE cycle; grant_o returns to 0.
- Requesters 0 and 2 assert together in IDLE with pointer=0 -> packet 0 first, then 2. Then 0, 1, 2 together with pointer=3 -> order 0, 1, 2 (scan from 3 wraps to 0).
- Back-pressure:
  - core_ready_i low 3 cycles mid-ABSORB -> in_ready_o[g] low for the same 3 cycles; no word lost or duplicated.
  - out_ready_i[g] low 5 cycles in SQUEEZE -> core_ready_o low 5 cycles; counter holds.
- out_words_i=0 -> exactly 1 output beat delivered, then RELEASE.
- Non-granted requester holds in_valid_i during another's packet -> its in_ready_o stays 0 and out_valid_o stays 0 throughout.
- Assert rst=0 asynchronously mid-SQUEEZE (between edges) -> all outputs 0 immediately; after rst=1, pointer=0 and a new request grants normally.
